trap_ctrl: RTL and testbench

Machine-mode trap sequencer driving the CSR file's trap-side write ports. Takes synchronous exceptions, the external interrupt and `mret` from the core, stalls the core while it runs, saves `mepc`/`mcause` through `mepcWe`/`mcauseWe`, then redirects the PC to the `mtvec` handler or back to `mepc`. Sits between the core's control path and the `csr` block.

---
 rtl/trap_ctrl_if.sv | 39 +++
 rtl/trap_ctrl.sv | 117 +++++++++++
 tb/tb_trap_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundle between the core/CSR side and the trap sequencer.
// Ports: exception/interrupt/mret requests and CSR reads in; CSR trap-side
// writes, trap enter/return pulses, stall and PC redirect out.
interface trap_ctrl_if;
  // requests and CSR state into the sequencer
  logic        excReq;
  logic [3:0]  excCause;
  logic [31:0] excPc;
  logic        irqReq;
  logic        mstatusMie;
  logic [31:0] nextPc;
  logic        mretReq;
  logic [31:0] mtvecDo;
  logic [31:0] mepcDo;
  // CSR writes and core control out of the sequencer
  logic        mepcWe;
  logic        mcauseWe;
  logic [31:0] mepcDi;
  logic [31:0] mcauseDi;
  logic        trapEnter;
  logic        trapReturn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;

  modport master (
    output excReq, excCause, excPc, irqReq, mstatusMie, nextPc, mretReq,
           mtvecDo, mepcDo,
    input  mepcWe, mcauseWe, mepcDi, mcauseDi, trapEnter, trapReturn,
           stall, redirect, redirectPc
  );

  modport slave (
    input  excReq, excCause, excPc, irqReq, mstatusMie, nextPc, mretReq,
           mtvecDo, mepcDo,
    output mepcWe, mcauseWe, mepcDi, mcauseDi, trapEnter, trapReturn,
           stall, redirect, redirectPc
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (IDLE -> SAVE -> ENTER, or IDLE -> RETURN).
// Ports: clk, reset (async active-low), bus (trap_ctrl_if.slave) carrying
// requests/CSR reads in and mepc/mcause writes, pulses, stall, redirect out.
// Macro TRAP_VECTORED_EN: interrupts with mtvec mode 01 jump to base + 44.
module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SAVE, ENTER, RETURN} state_t;

  state_t      state, state_nxt;
  logic [31:0] cause_q, epc_q;
  logic [31:0] cause_d, epc_d;
  logic        latch;
  logic        irq_take;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  // outputs built combinationally from registered state
  logic        mepc_we, mcause_we, trap_enter, trap_return, redirect;
  logic [31:0] redirect_pc;

  // a masked interrupt is simply not seen; it is taken later if still high
  assign irq_take  = bus.irqReq & bus.mstatusMie;
  assign trap_base = {bus.mtvecDo[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // cause_q[31] marks the latched trap as an interrupt
  always_comb begin
    trap_target = trap_base;
    if (cause_q[31] && (bus.mtvecDo[1:0] == 2'b01))
      trap_target = trap_base + 32'd44;
  end
`else
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_q <= 32'd0;
      epc_q   <= 32'd0;
    end else if (latch) begin
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_nxt   = state;
    latch       = 1'b0;
    cause_d     = 32'd0;
    epc_d       = 32'd0;
    mepc_we     = 1'b0;
    mcause_we   = 1'b0;
    trap_enter  = 1'b0;
    trap_return = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      IDLE: begin
        // priority: exception > interrupt > mret
        if (bus.excReq) begin
          latch     = 1'b1;
          cause_d   = {28'd0, bus.excCause};
          epc_d     = {bus.excPc[31:2], 2'b00};
          state_nxt = SAVE;
        end else if (irq_take) begin
          latch     = 1'b1;
          cause_d   = 32'h8000_000B;
          epc_d     = {bus.nextPc[31:2], 2'b00};
          state_nxt = SAVE;
        end else if (bus.mretReq) begin
          state_nxt = RETURN;
        end
      end
      SAVE: begin
        mepc_we    = 1'b1;
        mcause_we  = 1'b1;
        trap_enter = 1'b1;
        state_nxt  = ENTER;
      end
      ENTER: begin
        redirect    = 1'b1;
        redirect_pc = trap_target;
        state_nxt   = IDLE;
      end
      RETURN: begin
        redirect    = 1'b1;
        trap_return = 1'b1;
        redirect_pc = {bus.mepcDo[31:2], 2'b00};
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mepcWe     = mepc_we;
  assign bus.mcauseWe   = mcause_we;
  assign bus.mepcDi     = epc_q;
  assign bus.mcauseDi   = cause_q;
  assign bus.trapEnter  = trap_enter;
  assign bus.trapReturn = trap_return;
  assign bus.redirect   = redirect;
  assign bus.redirectPc = redirect_pc;
  assign bus.stall      = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl.
// Ports: none; drives the trap_ctrl_if master side and checks every output
// event (write enable, enter/return pulse, redirect) against a queue.
module tb_trap_ctrl;

  logic clk;
  logic reset;
  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_RPC = 32'h0000_032C;
`else
  localparam logic [31:0] IRQ_RPC = 32'h0000_0300;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        enter;
    logic        ret;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ev_num = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_save(input logic [31:0] epc, input logic [31:0] cause);
    exp_t e;
    e = '{we: 1'b1, epc: epc, cause: cause, enter: 1'b1, ret: 1'b0, redir: 1'b0, rpc: 32'd0};
    q.push_back(e);
  endtask

  task automatic push_redir(input logic ret, input logic [31:0] rpc);
    exp_t e;
    e = '{we: 1'b0, epc: 32'd0, cause: 32'd0, enter: 1'b0, ret: ret, redir: 1'b1, rpc: rpc};
    q.push_back(e);
  endtask

  // monitor: any event pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && (bus.mepcWe || bus.mcauseWe || bus.trapEnter ||
                  bus.trapReturn || bus.redirect)) begin
      ev_num++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event%0d: we=%0b enter=%0b ret=%0b redir=%0b pc=0x%08h",
                 ev_num, bus.mepcWe, bus.trapEnter, bus.trapReturn, bus.redirect,
                 bus.redirectPc);
      end else begin
        e = q.pop_front();
        chk($sformatf("ev%0d_mepcWe", ev_num), {31'd0, bus.mepcWe}, {31'd0, e.we});
        chk($sformatf("ev%0d_mcauseWe", ev_num), {31'd0, bus.mcauseWe}, {31'd0, e.we});
        chk($sformatf("ev%0d_trapEnter", ev_num), {31'd0, bus.trapEnter}, {31'd0, e.enter});
        chk($sformatf("ev%0d_trapReturn", ev_num), {31'd0, bus.trapReturn}, {31'd0, e.ret});
        chk($sformatf("ev%0d_redirect", ev_num), {31'd0, bus.redirect}, {31'd0, e.redir});
        chk($sformatf("ev%0d_redirectPc", ev_num), bus.redirectPc, e.rpc);
        if (e.we) begin
          chk($sformatf("ev%0d_mepcDi", ev_num), bus.mepcDi, e.epc);
          chk($sformatf("ev%0d_mcauseDi", ev_num), bus.mcauseDi, e.cause);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts stall-high samples over n cycles, sampling #1 after each edge
  task automatic count_stall(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.stall) c++;
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, "_mepcWe"}, {31'd0, bus.mepcWe}, 32'd0);
    chk({tag, "_mcauseWe"}, {31'd0, bus.mcauseWe}, 32'd0);
    chk({tag, "_trapEnter"}, {31'd0, bus.trapEnter}, 32'd0);
    chk({tag, "_trapReturn"}, {31'd0, bus.trapReturn}, 32'd0);
    chk({tag, "_redirect"}, {31'd0, bus.redirect}, 32'd0);
    chk({tag, "_redirectPc"}, bus.redirectPc, 32'd0);
    chk({tag, "_mepcDi"}, bus.mepcDi, 32'd0);
    chk({tag, "_mcauseDi"}, bus.mcauseDi, 32'd0);
  endtask

  initial begin
    int c;
    reset          = 1'b0;
    bus.excReq     = 1'b1;
    bus.excCause   = 4'd2;
    bus.excPc      = 32'h100;
    bus.irqReq     = 1'b0;
    bus.mstatusMie = 1'b0;
    bus.nextPc     = 32'h0;
    bus.mretReq    = 1'b0;
    bus.mtvecDo    = 32'h200;
    bus.mepcDo     = 32'h0;

    // reset held with an exception pending
    #3;
    check_all_zero("reset");
    tick();
    tick();
    check_all_zero("reset_held");
    bus.excReq = 1'b0;
    reset      = 1'b1;
    count_stall(3, c);
    chk("post_reset_stall_cycles", c, 0);

    // exception: cause 2 at 0x100, direct mtvec 0x200
    bus.excReq   = 1'b1;
    bus.excCause = 4'd2;
    bus.excPc    = 32'h100;
    bus.mtvecDo  = 32'h200;
    push_save(32'h100, 32'd2);
    push_redir(1'b0, 32'h200);
    tick();
    bus.excReq = 1'b0;
    count_stall(4, c);
    chk("exc_stall_cycles", c, 2);

    // interrupt with vectored-mode mtvec
    bus.irqReq     = 1'b1;
    bus.mstatusMie = 1'b1;
    bus.nextPc     = 32'h84;
    bus.mtvecDo    = 32'h301;
    push_save(32'h84, 32'h8000_000B);
    push_redir(1'b0, IRQ_RPC);
    tick();
    bus.irqReq = 1'b0;
    count_stall(4, c);
    chk("irq_stall_cycles", c, 2);

    // masked interrupt: nothing happens, then taken once MIE rises
    bus.irqReq     = 1'b1;
    bus.mstatusMie = 1'b0;
    count_stall(3, c);
    chk("irq_masked_stall_cycles", c, 0);
    bus.mstatusMie = 1'b1;
    push_save(32'h84, 32'h8000_000B);
    push_redir(1'b0, IRQ_RPC);
    tick();
    bus.irqReq = 1'b0;
    count_stall(4, c);
    chk("irq_unmasked_stall_cycles", c, 2);

    // mret back to mepc (low bits cleared)
    bus.mretReq = 1'b1;
    bus.mepcDo  = 32'h86;
    push_redir(1'b1, 32'h84);
    tick();
    bus.mretReq = 1'b0;
    count_stall(3, c);
    chk("mret_stall_cycles", c, 1);

    // simultaneous requests; irq and mret held through SAVE and ENTER
    bus.excReq   = 1'b1;
    bus.excCause = 4'd11;
    bus.excPc    = 32'h40;
    bus.irqReq   = 1'b1;
    bus.mretReq  = 1'b1;
    bus.mtvecDo  = 32'h200;
    push_save(32'h40, 32'd11);
    push_redir(1'b0, 32'h200);
    tick();
    bus.excReq = 1'b0;
    tick();
    tick();
    bus.irqReq  = 1'b0;
    bus.mretReq = 1'b0;
    chk("simul_back_idle_stall", {31'd0, bus.stall}, 32'd0);
    count_stall(3, c);
    chk("simul_no_extra_stall", c, 0);

    // reset pulse during SAVE aborts the sequence
    bus.excReq   = 1'b1;
    bus.excCause = 4'd3;
    bus.excPc    = 32'h10;
    tick();
    bus.excReq = 1'b0;
    chk("abort_in_save_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("abort_reset");
    tick();
    reset = 1'b1;
    count_stall(4, c);
    chk("abort_after_release_stall", c, 0);

    // every expected event must have been seen
    chk("scoreboard_leftover", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

endmodule
